// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: next-PC selects, bubble word,
// opcodes and the IF/ID bundle.
package mips_pkg;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [31:0] NOP_WORD = 32'h0;

   localparam logic [5:0] RTYPE = 6'h00;
   localparam logic [5:0] J     = 6'h02;
   localparam logic [5:0] BEQ   = 6'h04;
   localparam logic [5:0] BNE   = 6'h05;
   localparam logic [5:0] LW    = 6'h23;
   localparam logic [5:0] SW    = 6'h2B;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcPlus4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble insertion (flush).
// Synchronous active-low reset.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic   clk,
   input  logic   rstN,
   input  logic   stall,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         q.instr   <= NOP_INSTR;
         q.pcPlus4 <= 32'h0;
         q.valid   <= 1'b0;
      end else if (stall) begin
         q <= q;
      end else if (flush) begin
         q.instr   <= NOP_INSTR;
         q.pcPlus4 <= d.pcPlus4;
         q.valid   <= 1'b0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Define FETCH_PERF_EN to add saturating fetched/flushed/stalled counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
`ifdef FETCH_PERF_EN
   ,
   parameter int          PERF_W    = 32
`endif
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        stall,
   input  logic [1:0]  pcSrc,
   input  logic        IFFlush,
   input  logic [31:0] branchTarget,
   input  logic [31:0] jumpTarget,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemData,
   output logic [31:0] ifIdInstr,
   output logic [31:0] ifIdPcPlus4,
   output logic        ifIdValid
`ifdef FETCH_PERF_EN
   ,
   output logic [PERF_W-1:0] perfFetched,
   output logic [PERF_W-1:0] perfFlushed,
   output logic [PERF_W-1:0] perfStalled
`endif
);

   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [31:0] nextPc;
   if_id_t      ifD;
   if_id_t      ifQ;

   // Targets are word-aligned; the low bits never reach the PC.
   logic unusedLowBits;
   assign unusedLowBits = ^{branchTarget[1:0], jumpTarget[1:0]};

   assign imemAddr = pc;
   assign pcPlus4  = pc + 32'd4;

   always_comb begin
      nextPc = pcPlus4;
      case (pcSrc)
         PC_BRANCH: nextPc = {branchTarget[31:2], 2'b00};
         PC_JUMP:   nextPc = {jumpTarget[31:2], 2'b00};
         default:   nextPc = pcPlus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         pc <= RESET_PC;
      end else if (!stall) begin
         pc <= nextPc;
      end
   end

   always_comb begin
      ifD.instr   = imemData;
      ifD.pcPlus4 = pcPlus4;
      ifD.valid   = 1'b1;
   end

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id (
      .clk  (clk),
      .rstN (rstN),
      .stall(stall),
      .flush(IFFlush),
      .d    (ifD),
      .q    (ifQ)
   );

   assign ifIdInstr   = ifQ.instr;
   assign ifIdPcPlus4 = ifQ.pcPlus4;
   assign ifIdValid   = ifQ.valid;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rstN) begin
         perfFetched <= '0;
         perfFlushed <= '0;
         perfStalled <= '0;
      end else if (stall) begin
         if (!(&perfStalled)) perfStalled <= perfStalled + 1'b1;
      end else if (IFFlush) begin
         if (!(&perfFlushed)) perfFlushed <= perfFlushed + 1'b1;
      end else begin
         if (!(&perfFetched)) perfFetched <= perfFetched + 1'b1;
      end
   end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC and drives the instruction-memory address.
- Contains the IF/ID pipeline register that feeds the ID-stage decoder/controller.
- Consumes the controller's pcSrc and IFFlush, branch/jump targets computed in ID, and the stall from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted on flush/reset.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  synchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- pcSrc  in  2  0 = PC+4, 1 = branchTarget, 2 = jumpTarget, 3 = reserved (treated as 0)
- IFFlush  in  1  squash the instruction currently being fetched
- branchTarget  in  32  branch target from ID
- jumpTarget  in  32  jump target from ID
- imemAddr  out  32  instruction-memory address (= PC, combinational)
- imemData  in  32  instruction word, combinational read of imemAddr
- ifIdInstr  out  32  registered instruction to ID
- ifIdPcPlus4  out  32  registered PC+4 of that instruction
- ifIdValid  out  1  1 = ifIdInstr is a real fetched instruction

Behaviour:
- Reset is synchronous: on a clk edge with rstN=0:
  - pc <= RESET_PC
  - ifIdInstr <= NOP_INSTR
  - ifIdPcPlus4 <= 0
  - ifIdValid <= 0
  - perf counters <= 0
- Reset overrides all other inputs. Reset mid-stream discards any pending redirect.
- imemAddr = pc at all times. Fetch latency: instruction fetched in cycle N appears on ifIdInstr in cycle N+1.
- pcPlus4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Next-PC mux:
  - pcSrc 0 or 3 -> pcPlus4
  - pcSrc 1 -> {branchTarget[31:2],2'b00}
  - pcSrc 2 -> {jumpTarget[31:2],2'b00}
- Per edge, with rstN=1, priority is stall > IFFlush > normal:
  - stall=1: pc, ifIdInstr, ifIdPcPlus4 and ifIdValid all hold; pcSrc and IFFlush are ignored. The ID instruction is re-presented, so the redirect recurs next cycle.
  - stall=0, IFFlush=1: pc <= next-PC; ifIdInstr <= NOP_INSTR; ifIdPcPlus4 <= pcPlus4; ifIdValid <= 0.
  - stall=0, IFFlush=0: pc <= next-PC; ifIdInstr <= imemData; ifIdPcPlus4 <= pcPlus4; ifIdValid <= 1.
- A redirect without IFFlush (jump, pcSrc=2) still updates the PC. The one instruction already fetched enters ID normally (delay-slot semantics).
- No internal FSM beyond the PC/IF-ID registers. All outputs except imemAddr are registered.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds three outputs, each PERF_W wide, saturating at all-ones and reset to 0:
  - perfFetched: +1 per edge with stall=0 and IFFlush=0
  - perfFlushed: +1 per edge with stall=0 and IFFlush=1
  - perfStalled: +1 per edge with stall=1
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SEQ=2'd0, PC_BRANCH=2'd1, PC_JUMP=2'd2
  - NOP_WORD=32'h0
  - opcode constants (LW, SW, J, BEQ, BNE, RTYPE) shared with the controller
- One natural sub-module: if_id_reg, containing the IF/ID register with hold and flush.
- fetch_stage owns the PC register, the next-PC mux and the perf counters.

Test Plan:
- Reset: rstN=0 for 2 cycles, RESET_PC=0 -> imemAddr=0, ifIdInstr=0, ifIdValid=0. First cycle after release: imemAddr=0. Next cycle: imemAddr=4, ifIdInstr=imem[0], ifIdPcPlus4=4, ifIdValid=1.
- Sequential run over 8 cycles -> imemAddr steps 0,4,...,28. ifIdInstr matches imem words with one-cycle lag.
- Taken branch: pcSrc=1, IFFlush=1, branchTarget=32'h40 at pc=8 -> next cycle imemAddr=32'h40, ifIdInstr=0, ifIdValid=0. Following cycle: ifIdInstr=imem[0x40].
- Jump: pcSrc=2, jumpTarget=32'h103 -> imemAddr=32'h100, ifIdValid stays 1.
- Stall with simultaneous IFFlush=1 and pcSrc=1 for 2 cycles -> pc and IF/ID unchanged both cycles. Redirect takes effect on the first non-stalled edge.
- Wrap and mid-run reset: pc=32'hFFFF_FFFC -> next imemAddr=0. Asserting rstN=0 during a branch redirect -> pc=RESET_PC, ifIdValid=0. With FETCH_PERF_EN defined, all three counters read 0 after reset.
